// File: rtl/hour_reg_bcd.sv
// hour_reg_bcd: binary 0-23 hour count with registered BCD display in 24h or 12h/pm format.
module hour_reg_bcd (
  input  logic       clk,
  input  logic       resetn,
  input  logic       set,
  input  logic       inc,
  input  logic       mode_24,
  input  logic [1:0] new_tens,
  input  logic [3:0] new_ones,
  input  logic       new_pm,
  output logic [1:0] Q_tens,
  output logic [3:0] Q_ones,
  output logic       pm,
  output logic       day_roll,
  output logic       set_err
);
  logic [4:0] h_q, h_d, set_h, map12, disp;
  logic [5:0] v;
  logic [1:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       pm_q, pm_d, day_roll_q, day_roll_d, set_err_q, set_err_d, valid, wrap;
  always_comb begin
    v = 6'(new_tens) * 6'd10 + 6'(new_ones);
    map12 = v == 6'd12 ? (new_pm ? 5'd12 : 5'd0) : (new_pm ? v[4:0] + 5'd12 : v[4:0]);
    valid = new_ones <= 4'd9 && (mode_24 ? v <= 6'd23 : (v >= 6'd1 && v <= 6'd12));
    set_h = mode_24 ? v[4:0] : map12;
    wrap = h_q == 5'd23;
    h_d = set ? (valid ? set_h : h_q) : inc ? (wrap ? 5'd0 : h_q + 5'd1) : h_q;
    day_roll_d = !set && inc && wrap;
    set_err_d = set && !valid;
    // display tracks the next count so digits change on the same edge as h
    disp = mode_24 ? h_d : h_d == 5'd0 ? 5'd12 : h_d > 5'd12 ? h_d - 5'd12 : h_d;
    pm_d = !mode_24 && h_d >= 5'd12;
    tens_d = disp >= 5'd20 ? 2'd2 : disp >= 5'd10 ? 2'd1 : 2'd0;
    ones_d = tens_d == 2'd2 ? 4'(disp - 5'd20) : tens_d == 2'd1 ? 4'(disp - 5'd10) : disp[3:0];
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      h_q        <= 5'd0;
      tens_q     <= mode_24 ? 2'd0 : 2'd1;
      ones_q     <= mode_24 ? 4'd0 : 4'd2;
      pm_q       <= 1'b0;
      day_roll_q <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      h_q        <= h_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      pm_q       <= pm_d;
      day_roll_q <= day_roll_d;
      set_err_q  <= set_err_d;
    end
  end
  assign Q_tens   = tens_q;
  assign Q_ones   = ones_q;
  assign pm       = pm_q;
  assign day_roll = day_roll_q;
  assign set_err  = set_err_q;
endmodule

// File: tb/tb_hour_reg_bcd.sv
// tb_hour_reg_bcd: directed plus random stimulus against an integer hour model.
module tb_hour_reg_bcd;
  logic clk = 1'b0, resetn = 1'b0, set = 1'b0, inc = 1'b0, mode_24 = 1'b1, new_pm = 1'b0;
  logic [1:0] new_tens = 2'd0;
  logic [3:0] new_ones = 4'd0;
  logic [1:0] Q_tens;
  logic [3:0] Q_ones;
  logic pm, day_roll, set_err;
  int errors = 0, checks = 0;
  int h_m = 0, dr_m = 0, se_m = 0, mode_m = 1;
  hour_reg_bcd dut (
    .clk(clk), .resetn(resetn), .set(set), .inc(inc), .mode_24(mode_24),
    .new_tens(new_tens), .new_ones(new_ones), .new_pm(new_pm),
    .Q_tens(Q_tens), .Q_ones(Q_ones), .pm(pm), .day_roll(day_roll), .set_err(set_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    int v, disp, ok, nh;
    @(posedge clk);
    mode_m = mode_24;
    dr_m = 0;
    se_m = 0;
    if (!resetn) h_m = 0;
    else if (set) begin
      v = 10 * new_tens + new_ones;
      ok = mode_24 ? (new_ones <= 9 && v <= 23) : (new_ones <= 9 && v >= 1 && v <= 12);
      nh = mode_24 ? v : (v % 12) + (new_pm ? 12 : 0);
      if (ok != 0) h_m = nh;
      else se_m = 1;
    end else if (inc) begin
      dr_m = (h_m == 23);
      h_m = (h_m + 1) % 24;
    end
    #1;
    disp = mode_m != 0 ? h_m : (h_m % 12 == 0 ? 12 : h_m % 12);
    check("tens", Q_tens, disp / 10);
    check("ones", Q_ones, disp % 10);
    check("pm", pm, (mode_m == 0 && h_m >= 12) ? 1 : 0);
    check("day_roll", day_roll, dr_m);
    check("set_err", set_err, se_m);
  endtask
  task automatic load(input bit m, input int t, input int o, input bit p);
    mode_24 = m; new_tens = 2'(t); new_ones = 4'(o); new_pm = p; set = 1'b1;
    step();
    set = 1'b0;
  endtask
  initial begin
    step();
    check("rst24_q", {Q_tens, Q_ones}, 0);
    resetn = 1'b1;
    repeat (23) begin inc = 1'b1; step(); inc = 1'b0; step(); end
    check("h23_tens", Q_tens, 2);
    check("h23_ones", Q_ones, 3);
    inc = 1'b1; step(); inc = 1'b0;
    check("wrap_q", {Q_tens, Q_ones}, 0);
    check("wrap_roll", day_roll, 1);
    step();
    check("roll_clear", day_roll, 0);
    mode_24 = 1'b0; resetn = 1'b0; step(); resetn = 1'b1;
    check("rst12_ones", Q_ones, 2);
    check("rst12_pm", pm, 0);
    repeat (12) begin inc = 1'b1; step(); inc = 1'b0; step(); end
    check("noon_pm", pm, 1);
    inc = 1'b1; step(); inc = 1'b0;
    check("1pm_ones", Q_ones, 1);
    load(1'b0, 0, 7, 1'b1);
    check("7pm_ones", Q_ones, 7);
    mode_24 = 1'b1; step();
    check("19_tens", Q_tens, 1);
    check("19_ones", Q_ones, 9);
    load(1'b1, 2, 4, 1'b0); check("err_24", set_err, 1); step();
    load(1'b1, 1, 10, 1'b0); check("err_1A", set_err, 1); step();
    load(1'b0, 0, 0, 1'b0); check("err_00", set_err, 1); step();
    load(1'b0, 1, 3, 1'b1); check("err_13", set_err, 1); step();
    check("err_clear", set_err, 0);
    inc = 1'b1; load(1'b1, 0, 5, 1'b0);
    check("set_wins", Q_ones, 5);
    step(); inc = 1'b0;
    check("inc_after", Q_ones, 6);
    load(1'b1, 2, 3, 1'b0);
    load(1'b1, 0, 0, 1'b0);
    check("set0_noroll", day_roll, 0);
    load(1'b1, 2, 3, 1'b0);
    resetn = 1'b0; inc = 1'b1; step();
    check("rst_inc_roll", day_roll, 0);
    resetn = 1'b1; inc = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      resetn = ($urandom_range(99) >= 3);
      set = ($urandom_range(99) < 15);
      inc = ($urandom_range(99) < 40);
      if ($urandom_range(99) < 5) mode_24 = ~mode_24;
      new_tens = 2'($urandom_range(3));
      new_ones = 4'($urandom_range(15));
      new_pm = 1'($urandom_range(1));
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
